call_stack: RTL and testbench

//  Parametrised hardware return stack for the CPU; generational successor to the fixed 12-bit PC stack.

---
 rtl/call_stack.sv | 173 +++++++++++++++++
 tb/tb_call_stack.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack
//   Hardware return stack for the CPU. Saves {PC, flags, interrupt-frame}
//   on JSB / interrupt entry and restores them on RET / RETI. Supports
//   tail-call replace (push+pop), sticky error reporting and RET/RETI
//   frame-type checking.
//
// Parameters
//   ADDR_W  PC width in bits
//   FLAG_W  saved flag bits per frame
//   DEPTH   number of frames (any integer >= 2)
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-low
//   clk_en_i     state updates only when 1
//   push_i       push a frame
//   pop_i        pop a frame
//   int_frame_i  pushed frame is an interrupt frame
//   reti_i       pop is a RETI (0 = RET)
//   pc_i         return PC to save
//   flags_i      flags to save
//   err_clr_i    clear sticky errors
//   top_pc_o     PC of top-of-stack frame (0 when empty)
//   top_flags_o  flags of top-of-stack frame (0 when empty)
//   top_int_o    top frame is an interrupt frame (0 when empty)
//   count_o      frames held, 0..DEPTH
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
//   err_o        sticky {mismatch, underflow, overflow}
//
// Configuration
//   STACK_WRAP_EN  when defined, a push on a full stack overwrites the
//                  oldest frame (circular storage) instead of being dropped;
//                  err_o[0] is still raised as a warning.
// ---------------------------------------------------------------------------
module call_stack #(
    parameter int ADDR_W = 12,
    parameter int FLAG_W = 2,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clk_en_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       int_frame_i,
    input  logic                       reti_i,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic [FLAG_W-1:0]          flags_i,
    input  logic                       err_clr_i,
    output logic [ADDR_W-1:0]          top_pc_o,
    output logic [FLAG_W-1:0]          top_flags_o,
    output logic                       top_int_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [2:0]                 err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [FLAG_W-1:0] flags;
        logic              is_int;
    } frame_t;

    frame_t            mem [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    // Next free slot. In linear use it always equals count; in circular use
    // it wraps modulo DEPTH, so one pointer serves both builds.
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]        err_q, err_d;

    logic [PTR_W-1:0]  top_ptr;
    frame_t            top_frame;
    frame_t            new_frame;
    logic              empty, full;
    logic              replace, push_only, pop_only, pop_valid;
    logic              mismatch, underflow, overflow;
    logic              we;
    logic [PTR_W-1:0]  wr_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
    endfunction

    // NOTE: combinational logic uses blocking '=' with every output given a
    // default first, so no latch is inferred on any path.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(DEPTH));
        top_ptr   = ptr_dec(wr_ptr_q);
        top_frame = empty ? '0 : mem[top_ptr];
        new_frame = '{pc: pc_i, flags: flags_i, is_int: int_frame_i};

        // Push+pop on an empty stack degrades to a plain push.
        replace   = push_i && pop_i && !empty;
        push_only = push_i && (!pop_i || empty);
        pop_only  = pop_i && !push_i;
        pop_valid = pop_i && !empty;

        // Mismatch is judged against the outgoing frame, also on replace.
        mismatch  = pop_valid && (reti_i != top_frame.is_int);
        underflow = pop_only && empty;
        overflow  = push_only && full;

        we       = 1'b0;
        wr_idx   = wr_ptr_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;

        if (replace) begin
            we     = 1'b1;
            wr_idx = top_ptr;
        end else if (push_only) begin
            if (!full) begin
                we       = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + CNT_W'(1);
            end else begin
`ifdef STACK_WRAP_EN
                // When full, wr_ptr_q addresses the oldest frame.
                we       = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
`endif
            end
        end else if (pop_only && !empty) begin
            wr_ptr_d = ptr_dec(wr_ptr_q);
            count_d  = count_q - CNT_W'(1);
        end

        // A newly raised error wins over a simultaneous clear.
        err_d = (err_clr_i ? 3'b000 : err_q) | {mismatch, underflow, overflow};
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            err_q    <= '0;
        end else if (clk_en_i) begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the frame RAM has no reset; validity is tracked by count_q alone.
    // rst_i gates the write so nothing lands while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i && clk_en_i && we) begin
            mem[wr_idx] <= new_frame;
        end
    end

    assign top_pc_o    = top_frame.pc;
    assign top_flags_o = top_frame.flags;
    assign top_int_o   = top_frame.is_int;
    assign count_o     = count_q;
    assign empty_o     = empty;
    assign full_o      = full;
    assign err_o       = err_q;

endmodule

// File: tb/tb_call_stack.sv
// ---------------------------------------------------------------------------
// tb_call_stack
//   Self-checking bench for call_stack (default parameters). A queue-based
//   reference stack predicts each cycle's outputs; the prediction is pushed
//   to a scoreboard when stimulus is driven and popped/compared after the
//   clock edge. Honours STACK_WRAP_EN when defined.
// ---------------------------------------------------------------------------
module tb_call_stack;

    localparam int ADDR_W = 12;
    localparam int FLAG_W = 2;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              clk_en_i = 1'b0;
    logic              push_i = 1'b0;
    logic              pop_i = 1'b0;
    logic              int_frame_i = 1'b0;
    logic              reti_i = 1'b0;
    logic [ADDR_W-1:0] pc_i = '0;
    logic [FLAG_W-1:0] flags_i = '0;
    logic              err_clr_i = 1'b0;
    logic [ADDR_W-1:0] top_pc_o;
    logic [FLAG_W-1:0] top_flags_o;
    logic              top_int_o;
    logic [CNT_W-1:0]  count_o;
    logic              empty_o;
    logic              full_o;
    logic [2:0]        err_o;

    call_stack #(.ADDR_W(ADDR_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clk_en_i    (clk_en_i),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .int_frame_i (int_frame_i),
        .reti_i      (reti_i),
        .pc_i        (pc_i),
        .flags_i     (flags_i),
        .err_clr_i   (err_clr_i),
        .top_pc_o    (top_pc_o),
        .top_flags_o (top_flags_o),
        .top_int_o   (top_int_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [FLAG_W-1:0] fl;
        logic              it;
    } mframe_t;

    typedef struct {
        int                cnt;
        logic [ADDR_W-1:0] pc;
        logic [FLAG_W-1:0] fl;
        logic              it;
        logic              empty;
        logic              full;
        logic [2:0]        err;
    } exp_t;

    mframe_t    mq[$];
    exp_t       exp_q[$];
    logic [2:0] err_m = '0;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Snapshot of what the outputs should read given the current model.
    function automatic exp_t model_snapshot();
        exp_t e;
        e.cnt   = mq.size();
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.err   = err_m;
        if (mq.size() > 0) begin
            e.pc = mq[mq.size()-1].pc;
            e.fl = mq[mq.size()-1].fl;
            e.it = mq[mq.size()-1].it;
        end else begin
            e.pc = '0;
            e.fl = '0;
            e.it = 1'b0;
        end
        return e;
    endfunction

    task automatic compare_next(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "/count"}, 32'(count_o),     32'(e.cnt));
            check({tag, "/pc"},    32'(top_pc_o),    32'(e.pc));
            check({tag, "/flags"}, 32'(top_flags_o), 32'(e.fl));
            check({tag, "/int"},   32'(top_int_o),   32'(e.it));
            check({tag, "/empty"}, 32'(empty_o),     32'(e.empty));
            check({tag, "/full"},  32'(full_o),      32'(e.full));
            check({tag, "/err"},   32'(err_o),       32'(e.err));
        end
    endtask

    // One clocked operation: drive, predict, enqueue, then compare after edge.
    task automatic op(input string tag, input bit en, input bit push, input bit pop,
                      input bit it, input bit reti, input bit clr,
                      input logic [ADDR_W-1:0] pc, input logic [FLAG_W-1:0] fl);
        mframe_t    nf;
        logic [2:0] new_err;
        bit         emp, ful;
        @(negedge clk_i);
        clk_en_i = en; push_i = push; pop_i = pop; int_frame_i = it;
        reti_i = reti; err_clr_i = clr; pc_i = pc; flags_i = fl;

        if (en) begin
            nf      = '{pc: pc, fl: fl, it: it};
            new_err = 3'b000;
            emp     = (mq.size() == 0);
            ful     = (mq.size() == DEPTH);
            if (pop && !emp && (reti != mq[mq.size()-1].it)) new_err[2] = 1'b1;
            if (push && pop && !emp) begin
                mq[mq.size()-1] = nf;
            end else if (push) begin
                if (!ful) begin
                    mq.push_back(nf);
                end else begin
                    new_err[0] = 1'b1;
`ifdef STACK_WRAP_EN
                    void'(mq.pop_front());
                    mq.push_back(nf);
`endif
                end
            end else if (pop) begin
                if (emp) new_err[1] = 1'b1;
                else void'(mq.pop_back());
            end
            err_m = (clr ? 3'b000 : err_m) | new_err;
        end
        exp_q.push_back(model_snapshot());

        @(posedge clk_i);
        #1;
        compare_next(tag);
    endtask

    task automatic idle_inputs();
        clk_en_i = 1'b1; push_i = 1'b0; pop_i = 1'b0; int_frame_i = 1'b0;
        reti_i = 1'b0; err_clr_i = 1'b0; pc_i = '0; flags_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        rst_i = 1'b0;
        idle_inputs();
        #12;
        exp_q.push_back(model_snapshot());
        compare_next("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Basic push.
        op("push123", 1, 1, 0, 0, 0, 0, 12'h123, 2'b10);

        // Valid pop, then pop on empty (underflow), clear.
        op("pop_ok",    1, 0, 1, 0, 0, 0, '0, '0);
        op("pop_empty", 1, 0, 1, 0, 0, 0, '0, '0);
        op("clr",       1, 0, 0, 0, 0, 1, '0, '0);

        // Error raised in the same cycle as a clear wins.
        op("pop_empty_clr", 1, 0, 1, 0, 0, 1, '0, '0);
        op("clr2",          1, 0, 0, 0, 0, 1, '0, '0);

        // Interrupt frame popped with RET -> mismatch, pop still completes.
        op("push_int", 1, 1, 0, 1, 0, 0, 12'h200, 2'b01);
        op("ret_int",  1, 0, 1, 0, 0, 0, '0, '0);
        op("clr3",     1, 0, 0, 0, 0, 1, '0, '0);
        // Matching RETI gives no error.
        op("push_int2", 1, 1, 0, 1, 0, 0, 12'h2A0, 2'b11);
        op("reti_ok",   1, 0, 1, 0, 1, 0, '0, '0);

        // Fill to DEPTH, overflow push, replace while full, then drain.
        for (int i = 0; i < DEPTH; i++)
            op("fill", 1, 1, 0, 0, 0, 0, 12'(i), 2'(i));
        op("overflow",     1, 1, 0, 0, 0, 0, 12'h0AA, 2'b11);
        op("clr4",         1, 0, 0, 0, 0, 1, '0, '0);
        op("replace_full", 1, 1, 1, 0, 0, 0, 12'h0BB, 2'b01);
        for (int i = 0; i < DEPTH; i++)
            op("drain", 1, 0, 1, 0, 0, 0, '0, '0);

        // Push+pop on empty acts as push; then tail-call replace.
        op("pp_empty", 1, 1, 1, 0, 0, 0, 12'h040, 2'b00);
        op("pop040",   1, 0, 1, 0, 0, 0, '0, '0);
        op("push010",  1, 1, 0, 0, 0, 0, 12'h010, 2'b01);
        op("push020",  1, 1, 0, 0, 0, 0, 12'h020, 2'b10);
        op("tailcall", 1, 1, 1, 0, 0, 0, 12'h030, 2'b11);
        op("pop030",   1, 0, 1, 0, 0, 0, '0, '0);

        // Disabled clock enable holds everything.
        op("en_off_push", 0, 1, 0, 0, 0, 0, 12'h3FF, 2'b11);
        op("en_off_pop",  0, 0, 1, 0, 0, 1, '0, '0);

        // Asynchronous reset mid-cycle with an error pending and a push in flight.
        op("pop_last", 1, 0, 1, 0, 0, 0, '0, '0);
        op("underflow_pre_rst", 1, 0, 1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++)
            op("pre_rst_push", 1, 1, 0, 0, 0, 0, 12'(12'h100 + i), 2'b01);
        @(negedge clk_i);
        push_i = 1'b1; pc_i = 12'h777;
        #2;
        rst_i = 1'b0;
        #1;
        mq.delete();
        err_m = '0;
        exp_q.push_back(model_snapshot());
        compare_next("async_rst");
        @(posedge clk_i);
        #1;
        exp_q.push_back(model_snapshot());
        compare_next("rst_held");
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
        op("post_rst_idle", 1, 0, 0, 0, 0, 0, '0, '0);
        op("post_rst_push", 1, 1, 0, 0, 0, 0, 12'h321, 2'b01);
        op("post_rst_pop",  1, 0, 1, 0, 0, 0, '0, '0);

        if (exp_q.size() != 0)
            check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
